serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Downstream consumer of the parallel-load shift register's serial output (SO): recovers framed words from the idle-high serial line.
- Frame format, one bit per bit strobe: 1 start bit (0), WIDTH data bits, 1 stop bit (1).
- Presents each received word on a parallel bus with a one-cycle VALID strobe and flags a bad stop bit with FERR.
- Sits between the serializer and the lab's display/checker logic.

Parameters:
- WIDTH, 8: number of data bits per frame; legal range 2..16.
- MSB_FIRST, 1: 1 = first data bit received lands in PDATA[WIDTH-1]; 0 = it lands in PDATA[0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bit strobe; line is sampled only in cycles with en=1 (tie high for one bit per clk).
- SI  input  1  serial line, idle high; sourced synchronously from the shift register SO.
- PDATA  output  WIDTH  last correctly framed word; registered.
- VALID  output  1  one-cycle pulse: PDATA updated this cycle.
- FERR  output  1  one-cycle pulse: stop bit sampled as 0.
- BUSY  output  1  high while a frame is in progress (not IDLE).

Behaviour:
- Reset (async assert, sync release): state=IDLE, bit counter=0, internal shift reg=0, PDATA=0, VALID=0, FERR=0, BUSY=0.
- Reset mid-frame: the frame is aborted immediately; no VALID or FERR is generated for it.
- All transitions are gated by en. With en=0, state, counter and shift reg hold, and VALID/FERR are 0.
- IDLE: on en & SI=0, go to DATA with counter=0. On en & SI=1, stay.
- DATA: on each en, shift SI into the internal reg and increment the counter.
  - MSB_FIRST=1: shift left, SI enters at bit 0.
  - MSB_FIRST=0: shift right, SI enters at bit WIDTH-1.
  - When the counter reaches WIDTH-1 (the WIDTH-th bit is sampled), go to STOP.
- STOP: on en:
  - SI=1: PDATA <= shift reg, VALID=1 for exactly that cycle, FERR=0.
  - SI=0: FERR=1 for that cycle, PDATA holds its old value, VALID=0.
  - Either way, go to IDLE.
- Latency: VALID asserts in the clock cycle following the en-qualified stop-bit sample edge (registered output); PDATA becomes valid on that same edge.
- Back-to-back frames: IDLE may see the next start bit on the very next en after the stop bit. No idle gap is required.
- After FERR, the line may still be low. IDLE treats that low as a new start bit; this is the documented behaviour and no resync or hunt logic is added.
- BUSY = (state != IDLE), registered.
- VALID and FERR are never high together.
- Counter width: clog2(WIDTH) bits, computed by a constant function; the counter never wraps inside a frame.

Decomposition:
- Shared include serial_defs.vh: state encodings (IDLE=2'd0, DATA=2'd1, STOP=2'd2; 2'd3 is unreachable and decodes to IDLE) and the clog2 constant function, reused by the serializer controller.
- One sub-module: rx_bit_counter (enable, clear, terminal-count output for WIDTH-1).
- FSM, shift register and output registers stay in serial_frame_rx.

Test Plan:
- Reset, then line idle high for 20 clk with en=1 -> PDATA=8'h00, VALID, FERR and BUSY stay 0.
- en=1; bits 0,0,1,0,1,1,0,0,1,1 (start, 8'h59 MSB first, stop) -> VALID=1 for one cycle, PDATA=8'h59, FERR=0; BUSY high for 9 cycles, starting the cycle after the start-bit edge.
- MSB_FIRST=0 with the same line sequence -> PDATA=8'h9A.
- Stop bit forced 0 after data 8'hA5 -> FERR=1 for one cycle, PDATA keeps the previous value 8'h59, VALID=0.
- en pulsed every 4th clk, frames 8'h3C then 8'hC3 back-to-back with no gap -> two VALID pulses 40 clk apart, PDATA=8'h3C then 8'hC3.
- rst asserted asynchronously (between clock edges) after 4 data bits -> outputs clear immediately, no VALID/FERR; the next full frame 8'h0F is received correctly.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared serial-link definitions: FSM state encodings and a constant clog2.
// Reused by the serializer controller so both ends agree on encodings.
package serial_frame_rx_pkg;

    // 2'd3 is never entered; decoders treat it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for one frame: synchronous clear, increment, and a
// terminal-count flag when the WIDTH-th bit is being sampled.
module rx_bit_counter
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = clog2(WIDTH);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// Receives start/WIDTH data/stop frames from an idle-high serial line, sampled on en.
// Good frames update PDATA with a one-cycle VALID; a low stop bit gives a one-cycle FERR.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             SI,
    output logic [WIDTH-1:0] PDATA,
    output logic             VALID,
    output logic             FERR,
    output logic             BUSY
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             shift_en;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic             valid_nxt;
    logic             ferr_nxt;

    rx_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clr),
        .inc  (cnt_inc),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && !SI) state_nxt = DATA;
            DATA:    if (en && cnt_tc) state_nxt = STOP;
            STOP:    if (en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter is cleared (not incremented) on the last data bit so it never wraps.
    always_comb begin
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = en;
            end
            DATA: begin
                shift_en = en;
                cnt_inc  = en && !cnt_tc;
                cnt_clr  = en && cnt_tc;
            end
            STOP: begin
                valid_nxt = en && SI;
                ferr_nxt  = en && !SI;
            end
            default: begin
                cnt_clr = en;
            end
        endcase
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {shreg[WIDTH-2:0], SI};
        end else begin : g_lsb
            assign shifted = {SI, shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PDATA <= '0;
            VALID <= 1'b0;
            FERR  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            VALID <= valid_nxt;
            FERR  <= ferr_nxt;
            BUSY  <= (state_nxt != IDLE);
            if (valid_nxt) begin
                PDATA <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench: MSB-first and LSB-first receivers share one serial line.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       si;
    logic [7:0] pdata_a, pdata_b;
    logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    int vld_a_n, ferr_a_n, busy_a_n, vld_b_n;
    int cyc = 0;
    int vld_cyc[$];
    logic [7:0] vld_dat_a[$];
    logic [7:0] vld_dat_b[$];

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .SI(si),
        .PDATA(pdata_a), .VALID(valid_a), .FERR(ferr_a), .BUSY(busy_a)
    );

    serial_frame_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .SI(si),
        .PDATA(pdata_b), .VALID(valid_b), .FERR(ferr_b), .BUSY(busy_b)
    );

    always @(negedge clk) begin
        cyc++;
        if (valid_a) begin
            vld_a_n++;
            vld_cyc.push_back(cyc);
            vld_dat_a.push_back(pdata_a);
        end
        if (valid_b) begin
            vld_b_n++;
            vld_dat_b.push_back(pdata_b);
        end
        if (ferr_a) ferr_a_n++;
        if (busy_a) busy_a_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        vld_a_n  = 0;
        ferr_a_n = 0;
        busy_a_n = 0;
        vld_b_n  = 0;
        vld_cyc.delete();
        vld_dat_a.delete();
        vld_dat_b.delete();
    endtask

    // Drive en/SI at the falling edge, return just after the next rising edge.
    task automatic drive(input logic e, input logic s);
        @(negedge clk);
        en = e;
        si = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) drive(1'b0, b);
        drive(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        send_bit(1'b0, gap);
        for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
        send_bit(stop, gap);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        si  = 1'b1;
        clear_counts();

        // Reset state
        #2 rst = 1'b1;
        #2;
        chk("rst_pdata", pdata_a, 8'h00);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_ferr",  ferr_a,  1'b0);
        chk("rst_busy",  busy_a,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle-high line for 20 clocks
        clear_counts();
        repeat (20) drive(1'b1, 1'b1);
        chk("idle_pdata", pdata_a, 8'h00);
        chk("idle_vld_n", vld_a_n, 0);
        chk("idle_ferr_n", ferr_a_n, 0);
        chk("idle_busy_n", busy_a_n, 0);

        // Frame 8'h59: MSB-first sees 59, LSB-first sees 9A
        clear_counts();
        send_frame(8'h59, 1'b1, 0);
        chk("f59_valid", valid_a, 1'b1);
        chk("f59_ferr",  ferr_a,  1'b0);
        chk("f59_pdata", pdata_a, 8'h59);
        chk("f59_pdata_lsb", pdata_b, 8'h9A);
        chk("f59_valid_lsb", valid_b, 1'b1);
        drive(1'b1, 1'b1);
        chk("f59_valid_drop", valid_a, 1'b0);
        chk("f59_vld_n",  vld_a_n,  1);
        chk("f59_busy_n", busy_a_n, 9);

        // Frame 8'hA5 with a low stop bit
        clear_counts();
        send_frame(8'hA5, 1'b0, 0);
        chk("fa5_ferr",  ferr_a,  1'b1);
        chk("fa5_valid", valid_a, 1'b0);
        chk("fa5_pdata_hold", pdata_a, 8'h59);
        chk("fa5_pdata_lsb_hold", pdata_b, 8'h9A);
        drive(1'b1, 1'b1);
        chk("fa5_ferr_drop", ferr_a, 1'b0);
        chk("fa5_vld_n",  vld_a_n,  0);
        chk("fa5_ferr_n", ferr_a_n, 1);
        repeat (3) drive(1'b1, 1'b1);

        // en every 4th clock, back-to-back frames 3C then C3
        clear_counts();
        send_frame(8'h3C, 1'b1, 3);
        send_frame(8'hC3, 1'b1, 3);
        drive(1'b0, 1'b1);
        chk("b2b_vld_n", vld_a_n, 2);
        chk("b2b_ferr_n", ferr_a_n, 0);
        if (vld_cyc.size() == 2) begin
            chk("b2b_spacing", vld_cyc[1] - vld_cyc[0], 40);
            chk("b2b_data0", vld_dat_a[0], 8'h3C);
            chk("b2b_data1", vld_dat_a[1], 8'hC3);
        end else begin
            chk("b2b_pulses", vld_cyc.size(), 2);
        end
        chk("b2b_pdata_lsb", pdata_b, 8'hC3);

        // Async reset four data bits into a frame
        clear_counts();
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        chk("mid_busy_pre", busy_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy",  busy_a,  1'b0);
        chk("mid_pdata", pdata_a, 8'h00);
        chk("mid_valid", valid_a, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) drive(1'b1, 1'b1);
        chk("mid_vld_n",  vld_a_n,  0);
        chk("mid_ferr_n", ferr_a_n, 0);

        // Clean frame after the abort
        clear_counts();
        send_frame(8'h0F, 1'b1, 0);
        chk("f0f_valid", valid_a, 1'b1);
        chk("f0f_pdata", pdata_a, 8'h0F);
        chk("f0f_pdata_lsb", pdata_b, 8'hF0);
        drive(1'b1, 1'b1);
        chk("f0f_vld_n", vld_a_n, 1);
        chk("f0f_vld_n_lsb", vld_b_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
